pps_gen: RTL and testbench
==========================

PPS_GEN -- requirements
Module: pps_gen

Interface
REQ-001 Parameter: CNT_W, default 32, width of the period, width and counter quantities.
REQ-002 Parameter: TOL, default 16, lock tolerance in CLK cycles.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 Port: CLK  input  1  sole clock; all state changes on rising edge.
REQ-005 Port: RST_N  input  1  asynchronous active-low reset.
REQ-006 Port: enable  input  1  generator run enable.
REQ-007 Port: sync_en  input  1  permit discipline to external PPS.
REQ-008 Port: period  input  CNT_W  CLK cycles per second; values below 2 treated as 2.
REQ-009 Port: width  input  CNT_W  pulse high time in cycles; 0 means no pulse; values at or above period clamp to period-1.
REQ-010 Port: pps_in  input  1  external PPS, asynchronous to CLK.
REQ-011 Port: pps_out  output  1  generated PPS, registered.
REQ-012 Port: pps_tick  output  1  one-cycle strobe when the counter enters 0.
REQ-013 Port: sec_count  output  CNT_W  seconds elapsed, wraps modulo 2^CNT_W.
REQ-014 Port: phase_err  output  CNT_W  counter value captured at the last external edge.
REQ-015 Port: state  output  2  0=FREE, 1=ACQUIRE, 2=LOCKED, 3=HOLDOVER.
REQ-016 Port: locked  output  1  high exactly when state==LOCKED.

Function
REQ-017 Counter cnt SHALL count 0..period-1 and wrap to 0; pps_out SHALL be high exactly in cycles where cnt < effective width, registered alongside cnt.
REQ-018 pps_tick SHALL pulse for one cycle, and sec_count SHALL increment, whenever cnt enters 0 by wrap or by tick-producing realign.
REQ-019 pps_in SHALL pass a 2-flop synchronizer plus a delay flop; ext_edge = sync2 & ~sync3; cnt==0 SHALL occur at the 3rd rising CLK edge after pps_in is first sampled high.
REQ-020 Realign: cnt loaded 0 on the cycle after ext_edge; phase_err <= cnt at ext_edge; tick produced only if cnt > TOL at ext_edge.
REQ-021 Gap counter: cycles since last ext_edge, saturating, cleared on ext_edge.
REQ-022 enable=0: cnt held 0, pps_out 0, pps_tick 0, state forced FREE; sec_count and phase_err held.
REQ-023 FREE: no realign; when enable & sync_en -> ACQUIRE.
REQ-024 ACQUIRE: on ext_edge realign, -> LOCKED.
REQ-025 LOCKED: on ext_edge with cnt <= TOL or cnt >= period-TOL, realign and stay; otherwise realign and -> ACQUIRE; with gap == period+TOL and no edge -> HOLDOVER.
REQ-026 HOLDOVER: free-run; on ext_edge in tolerance, realign and -> LOCKED; out of tolerance, realign and -> ACQUIRE.
REQ-027 sync_en=0 in any state SHALL -> FREE next cycle without disturbing cnt.
REQ-028 ext_edge coincident with a natural wrap SHALL produce exactly one tick.
REQ-029 Changes to period or width SHALL take effect from the next cycle; if cnt >= new period, cnt wraps to 0 next cycle with tick.

Reset
REQ-030 While RST_N is low, the block SHALL hold: cnt=0, pps_out=0, pps_tick=0, sec_count=0, phase_err=0, gap=0, synchronizer flops=0, state=FREE, locked=0.
REQ-031 Reset assertion SHALL clear outputs asynchronously, including mid-pulse; the first count SHALL occur on the first CLK edge after RST_N deasserts.

Verification
REQ-032 Free-run: period=10, width=3, enable=1, sync_en=0 -> pps_out 3 high / 7 low repeating, tick every 10 cycles, sec_count 1,2,3...
REQ-033 Acquire: sync_en=1, TOL=1, pps_in rises so ext_edge sees cnt=6 -> phase_err=6, cnt=0 next cycle, one tick, state ACQUIRE->LOCKED.
REQ-034 Track: edges landing at cnt=0 -> no extra ticks, phase_err=0, stays LOCKED; edge at cnt=9 -> realign with tick, phase_err=9, stays LOCKED.
REQ-035 Slip: LOCKED, edge at cnt=5 -> realign, phase_err=5, state ACQUIRE, locked=0.
REQ-036 Loss: stop pps_in while LOCKED -> HOLDOVER when gap reaches 11, pps_out continues at period 10; restore edge at cnt=0 -> LOCKED.
REQ-037 Reset: assert RST_N low during pps_out high -> pps_out and all status outputs 0 immediately; after release, free-run restarts from cnt=0.

Source files
------------

// File: rtl/pps_gen.sv
// rtl/pps_gen.sv - PPS generator with lock/holdover discipline to an external PPS input
// Free-running second counter that realigns to a synchronized external PPS edge.
module pps_gen #(
   parameter int CNT_W = 32,
   parameter int TOL   = 16
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             enable,
   input  logic             sync_en,
   input  logic [CNT_W-1:0] period,
   input  logic [CNT_W-1:0] width,
   input  logic             pps_in,
   output logic             pps_out,
   output logic             pps_tick,
   output logic [CNT_W-1:0] sec_count,
   output logic [CNT_W-1:0] phase_err,
   output logic [1:0]       state,
   output logic             locked
);

   typedef enum logic [1:0] {
      FREE     = 2'd0,
      ACQUIRE  = 2'd1,
      LOCKED   = 2'd2,
      HOLDOVER = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] TOL_C = CNT_W'(TOL);
   localparam logic [CNT_W:0]   TOL_X = (CNT_W+1)'(TOL);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] gap_q, gap_d;
   logic [CNT_W-1:0] sec_count_q, sec_count_d;
   logic [CNT_W-1:0] phase_err_q, phase_err_d;
   logic             pps_out_q, pps_out_d;
   logic             pps_tick_q, pps_tick_d;
   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             sync3_q, sync3_d;

   logic [CNT_W-1:0] p_eff, last, w_eff;
   logic             ext_edge, wrap, in_tol, gap_full, realign;

   always_comb begin
      p_eff    = (period < CNT_W'(2)) ? CNT_W'(2) : period;
      last     = p_eff - CNT_W'(1);
      w_eff    = (width >= p_eff) ? last : width;
      ext_edge = sync2_q & ~sync3_q;
      // wrap also catches a counter stranded above a newly shortened period
      wrap     = (cnt_q >= last);
      in_tol   = (cnt_q <= TOL_C) || (({1'b0, cnt_q} + TOL_X) >= {1'b0, p_eff});
      gap_full = ({1'b0, gap_q} == ({1'b0, p_eff} + TOL_X));
      realign  = enable & sync_en & ext_edge & (state_q != FREE);

      sync1_d = pps_in;
      sync2_d = sync1_q;
      sync3_d = sync2_q;

      gap_d = ext_edge ? '0 : ((gap_q == '1) ? gap_q : gap_q + CNT_W'(1));

      cnt_d       = '0;
      pps_tick_d  = 1'b0;
      phase_err_d = phase_err_q;
      if (enable) begin
         if (!realign && !wrap) cnt_d = cnt_q + CNT_W'(1);
         // a realign landing on a natural wrap still yields a single tick
         pps_tick_d = realign ? ((cnt_q > TOL_C) || wrap) : wrap;
         if (ext_edge) phase_err_d = cnt_q;
      end
      pps_out_d   = enable & (cnt_d < w_eff);
      sec_count_d = sec_count_q + CNT_W'(pps_tick_d);

      state_d = state_q;
      if (!enable || !sync_en) begin
         state_d = FREE;
      end else begin
         case (state_q)
            FREE:     state_d = ACQUIRE;
            ACQUIRE:  if (ext_edge) state_d = LOCKED;
            LOCKED: begin
               if (ext_edge)      state_d = in_tol ? LOCKED : ACQUIRE;
               else if (gap_full) state_d = HOLDOVER;
            end
            HOLDOVER: if (ext_edge) state_d = in_tol ? LOCKED : ACQUIRE;
            default:  state_d = FREE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= FREE;
         cnt_q       <= '0;
         gap_q       <= '0;
         sec_count_q <= '0;
         phase_err_q <= '0;
         pps_out_q   <= 1'b0;
         pps_tick_q  <= 1'b0;
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         sync3_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         gap_q       <= gap_d;
         sec_count_q <= sec_count_d;
         phase_err_q <= phase_err_d;
         pps_out_q   <= pps_out_d;
         pps_tick_q  <= pps_tick_d;
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         sync3_q     <= sync3_d;
      end
   end

   assign pps_out   = pps_out_q;
   assign pps_tick  = pps_tick_q;
   assign sec_count = sec_count_q;
   assign phase_err = phase_err_q;
   assign state     = state_q;
   assign locked    = (state_q == LOCKED);

endmodule

// File: tb/tb_pps_gen.sv
// tb/tb_pps_gen.sv - self-checking bench for pps_gen against a behavioural reference model
// Directed scenarios followed by randomized external-PPS, period and width stimulus.
module tb_pps_gen;

   localparam int CNT_W = 32;
   localparam int TOL   = 1;

   logic             CLK;
   logic             RST_N;
   logic             enable;
   logic             sync_en;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] width;
   logic             pps_in;
   logic             pps_out;
   logic             pps_tick;
   logic [CNT_W-1:0] sec_count;
   logic [CNT_W-1:0] phase_err;
   logic [1:0]       state;
   logic             locked;

   pps_gen #(.CNT_W(CNT_W), .TOL(TOL)) dut (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .enable   (enable),
      .sync_en  (sync_en),
      .period   (period),
      .width    (width),
      .pps_in   (pps_in),
      .pps_out  (pps_out),
      .pps_tick (pps_tick),
      .sec_count(sec_count),
      .phase_err(phase_err),
      .state    (state),
      .locked   (locked)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_cmp  = 0;
   int n_fail = 0;

   // reference model state: counter position, outputs, lock state, edge history
   longint      m_cnt;
   longint      m_gap;
   bit          m_out;
   bit          m_tick;
   logic [31:0] m_sec;
   logic [31:0] m_phase;
   int          m_state;
   bit          m_hist[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_gap = 0; m_out = 0; m_tick = 0;
      m_sec = '0; m_phase = '0; m_state = 0;
      m_hist = '{0, 0, 0};
   endtask

   task automatic compare_all();
      chk("pps_out",   64'(pps_out),   64'(m_out));
      chk("pps_tick",  64'(pps_tick),  64'(m_tick));
      chk("sec_count", 64'(sec_count), 64'(m_sec));
      chk("phase_err", 64'(phase_err), 64'(m_phase));
      chk("state",     64'(state),     64'(m_state));
      chk("locked",    64'(locked),    64'(m_state == 2));
   endtask

   // one clock: predict from the rules, let the DUT clock, then compare
   task automatic step();
      longint p, w, nxt;
      bit ext, on_time, align, tick;
      int ns;
      p = (longint'(period) < 2) ? 2 : longint'(period);
      w = (longint'(width) >= p) ? p - 1 : longint'(width);
      ext = m_hist[1] && !m_hist[2];
      on_time = (m_cnt <= TOL) || (m_cnt >= p - TOL);
      align = enable && sync_en && ext && (m_state != 0);
      tick = enable && ((m_cnt >= p - 1) || (align && m_cnt > TOL));
      if (!enable) nxt = 0;
      else if (align) nxt = 0;
      else nxt = (m_cnt + 1) % p == 0 || m_cnt + 1 > p - 1 ? 0 : m_cnt + 1;
      ns = m_state;
      if (!enable || !sync_en) ns = 0;
      else if (m_state == 0) ns = 1;
      else if (m_state == 1) begin if (ext) ns = 2; end
      else if (ext) ns = on_time ? 2 : 1;
      else if (m_state == 2 && m_gap == p + TOL) ns = 3;
      @(posedge CLK);
      if (enable && ext) m_phase = m_cnt[31:0];
      m_gap   = ext ? 0 : ((m_gap >= 64'hFFFF_FFFF) ? m_gap : m_gap + 1);
      m_cnt   = nxt;
      m_tick  = tick;
      m_out   = enable && (nxt < w);
      m_sec   = m_sec + 32'(tick);
      m_state = ns;
      m_hist.push_front(pps_in);
      void'(m_hist.pop_back());
      #1;
      compare_all();
   endtask

   task automatic wait_cnt(input longint target);
      bit found;
      found = 0;
      for (int k = 0; k < 60 && !found; k++) begin
         if (m_cnt == target) found = 1;
         else step();
      end
      n_cmp++;
      assert (found) else begin
         n_fail++;
         $error("FAIL wait_cnt observed=timeout expected=cnt_%0d", target);
      end
   endtask

   // makes the synchronized edge visible while the counter sits at target (period 10)
   task automatic edge_at(input longint target);
      wait_cnt((target + 8) % 10);
      pps_in = 1'b1;
      step();
      step();
      pps_in = 1'b0;
      step();
   endtask

   initial begin
      int ticks, highs, ext_ph, ext_per;
      bit seen;
      RST_N = 1'b0; enable = 1'b0; sync_en = 1'b0; pps_in = 1'b0;
      period = 32'd10; width = 32'd3;
      model_reset();
      repeat (3) @(posedge CLK);
      #1;
      compare_all();
      enable = 1'b1;
      RST_N  = 1'b1;

      // free-run: 3 high / 7 low, one tick per 10 cycles
      ticks = 0; highs = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         ticks += int'(pps_tick);
         highs += int'(pps_out);
      end
      chk("free_ticks", 64'(ticks), 64'd3);
      chk("free_highs", 64'(highs), 64'd9);
      chk("free_sec",   64'(sec_count), 64'd3);

      // acquire at cnt 6
      sync_en = 1'b1;
      step();
      chk("acq_state", 64'(state), 64'd1);
      edge_at(6);
      chk("acq_phase", 64'(phase_err), 64'd6);
      chk("acq_tick",  64'(pps_tick),  64'd1);
      chk("acq_lock",  64'(locked),    64'd1);

      // track: edge on cnt 0 gives no tick, edge on cnt 9 one tick
      edge_at(0);
      chk("trk0_phase", 64'(phase_err), 64'd0);
      chk("trk0_tick",  64'(pps_tick),  64'd0);
      chk("trk0_state", 64'(state),     64'd2);
      edge_at(9);
      chk("trk9_phase", 64'(phase_err), 64'd9);
      chk("trk9_tick",  64'(pps_tick),  64'd1);
      chk("trk9_state", 64'(state),     64'd2);
      step();
      chk("trk9_single", 64'(pps_tick), 64'd0);

      // slip
      edge_at(5);
      chk("slip_phase",  64'(phase_err), 64'd5);
      chk("slip_state",  64'(state),     64'd1);
      chk("slip_locked", 64'(locked),    64'd0);
      edge_at(0);
      chk("relock_state", 64'(state), 64'd2);

      // loss of input, then holdover and recovery
      repeat (14) step();
      chk("hold_state", 64'(state), 64'd3);
      ticks = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         ticks += int'(pps_tick);
      end
      chk("hold_ticks", 64'(ticks), 64'd2);
      edge_at(0);
      chk("recover_state", 64'(state), 64'd2);

      // randomized external PPS with jitter, dropouts and setting changes
      ext_ph = 0; ext_per = 10;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 399) == 0) period = 32'($urandom_range(0, 14));
         if ($urandom_range(0, 199) == 0) width  = 32'($urandom_range(0, 16));
         if ($urandom_range(0, 149) == 0) sync_en = ~sync_en;
         enable = ($urandom_range(0, 299) != 0);
         ext_ph++;
         if (ext_ph >= ext_per) begin
            ext_ph = 0;
            ext_per = int'(period) + int'($urandom_range(0, 4)) - 2;
            if (ext_per < 4) ext_per = 4;
         end
         pps_in = (ext_ph < 2) && ($urandom_range(0, 19) != 0);
         step();
      end

      // asynchronous reset in the middle of a pulse
      enable = 1'b1; sync_en = 1'b0; pps_in = 1'b0;
      period = 32'd10; width = 32'd5;
      seen = 0;
      for (int k = 0; k < 40 && !seen; k++) begin
         step();
         if (m_out) seen = 1;
      end
      chk("rst_pre_high", 64'(pps_out), 64'd1);
      #2;
      RST_N = 1'b0;
      #1;
      chk("rst_async_out",   64'(pps_out),   64'd0);
      chk("rst_async_sec",   64'(sec_count), 64'd0);
      chk("rst_async_phase", 64'(phase_err), 64'd0);
      chk("rst_async_state", 64'(state),     64'd0);
      model_reset();
      @(posedge CLK);
      #1;
      compare_all();
      RST_N = 1'b1;
      highs = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         highs += int'(pps_out);
      end
      chk("rst_restart_highs", 64'(highs), 64'd5);
      chk("rst_restart_sec",   64'(sec_count), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
